// File: rtl/mem_pkg.sv
// mem_pkg: type codes, FSM states, byte-enable patterns and alignment helpers for mem_access_ctrl
package mem_pkg;
    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_BU = 3'd1;
    localparam logic [2:0] MEM_H  = 3'd2;
    localparam logic [2:0] MEM_HU = 3'd3;
    localparam logic [2:0] MEM_W  = 3'd4;
    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_H0  = 4'b0011;
    localparam logic [3:0] BE_H1  = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_e;
    function automatic logic is_byte(input logic [2:0] t);
        return t == MEM_B || t == MEM_BU;
    endfunction
    function automatic logic is_half(input logic [2:0] t);
        return t == MEM_H || t == MEM_HU;
    endfunction
    function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
        return (is_half(t) && a[0]) || (t == MEM_W && a != 2'b00);
    endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: selects the addressed byte/halfword lane of a memory word and extends it
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_type,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    // pick the lane, then sign- or zero-extend by access type; anything else is a full word
    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        o_data = (i_type == MEM_B)  ? {{24{w_byte[7]}}, w_byte} :
                 (i_type == MEM_BU) ? {24'd0, w_byte} :
                 (i_type == MEM_H)  ? {{16{w_half[15]}}, w_half} :
                 (i_type == MEM_HU) ? {16'd0, w_half} : i_word;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller with alignment check, req/ack port and stall
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ACK_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic [31:0] badvaddr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);
    state_e      r_state;
    logic [2:0]  r_type;
    logic [1:0]  r_off;
    logic [31:0] r_cnt;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_adel;
    logic        r_ades;
    logic        r_berr;
    logic [31:0] r_bv;
    logic        r_dm_req;
    logic        r_dm_we;
    logic [3:0]  r_dm_be;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic        w_mis;
    logic        w_rsv;
    logic        w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;

    load_extract u_ext (
        .i_word (dm_rdata),
        .i_type (r_type),
        .i_off  (r_off),
        .o_data (w_ext)
    );

    // request decode: error classification, store lanes and the ack-timeout condition
    always_comb begin
        w_mis   = misaligned(req_type, req_addr[1:0]);
        w_rsv   = req_type > MEM_W;
        w_be    = !req_we ? BE_W :
                  is_byte(req_type) ? BE_B0 << req_addr[1:0] :
                  is_half(req_type) ? (req_addr[1] ? BE_H1 : BE_H0) : BE_W;
        w_wdata = is_byte(req_type) ? {4{req_wdata[7:0]}} :
                  is_half(req_type) ? {2{req_wdata[15:0]}} : req_wdata;
        w_tmo   = (ACK_WAIT_MAX != 0) && (r_cnt == ACK_WAIT_MAX - 1);
    end

    // access FSM; every output except stall is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_type     <= MEM_B;
            r_off      <= 2'd0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_adel     <= 1'b0;
            r_ades     <= 1'b0;
            r_berr     <= 1'b0;
            r_bv       <= '0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_be    <= '0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && (w_mis || w_rsv)) begin
                        r_state <= S_ERR;
                        r_done  <= 1'b1;
                        r_adel  <= w_mis && !req_we;
                        r_ades  <= w_mis && req_we;
                        r_rdata <= '0;
                        if (w_mis) r_bv <= req_addr;
                    end else if (req_valid) begin
                        r_state    <= S_BUSY;
                        r_type     <= req_type;
                        r_off      <= req_addr[1:0];
                        r_cnt      <= '0;
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= req_we;
                        r_dm_be    <= w_be;
                        r_dm_addr  <= {req_addr[31:2], 2'b00};
                        r_dm_wdata <= req_we ? w_wdata : '0;
                    end
                end
                S_BUSY: begin
                    if (dm_ack) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_dm_req <= 1'b0;
                        if (!r_dm_we) r_rdata <= w_ext;
                    end else if (w_tmo) begin
                        r_state  <= S_ERR;
                        r_done   <= 1'b1;
                        r_berr   <= 1'b1;
                        r_dm_req <= 1'b0;
                        r_rdata  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_adel  <= 1'b0;
                    r_ades  <= 1'b0;
                    r_berr  <= 1'b0;
                end
            endcase
        end
    end

    assign stall    = (r_state == S_IDLE && req_valid) || r_state == S_BUSY;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign adel     = r_adel;
    assign ades     = r_ades;
    assign bus_err  = r_berr;
    assign badvaddr = r_bv;
    assign dm_req   = r_dm_req;
    assign dm_we    = r_dm_we;
    assign dm_be    = r_dm_be;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
endmodule
